// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and defaults for the round-robin mux arbiter.
// Holds the FSM state encoding and the select-width helper.
package rr_mux_arbiter_pkg;

  typedef enum logic {StIdle = 1'b0, StBusy = 1'b1} state_e;

  localparam int unsigned DefN       = 4;
  localparam int unsigned DefW       = 8;
  localparam int unsigned DefMaxHold = 4;

  // A select index is at least one bit wide, even for a single requester.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester/consumer bundle for the round-robin mux arbiter.
// The slave modport is the arbiter side; master is the producers/consumer side.
interface rr_mux_arbiter_if #(
  parameter int unsigned N    = rr_mux_arbiter_pkg::DefN,
  parameter int unsigned W    = rr_mux_arbiter_pkg::DefW,
  parameter int unsigned SelW = rr_mux_arbiter_pkg::idx_w(N)
);
  logic [N-1:0]    req;
  logic [N*W-1:0]  data_in;
  logic [N-1:0]    ack;
  logic [N-1:0]    grant;
  logic [SelW-1:0] sel;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_ready;

  modport slave (
    input  req, data_in, out_ready,
    output ack, grant, sel, out_valid, out_data
  );

  modport master (
    output req, data_in, out_ready,
    input  ack, grant, sel, out_valid, out_data
  );
endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1
// modulo N, returned as one-hot, index and an any-request flag.
module rr_mux_arbiter_pick import rr_mux_arbiter_pkg::*; #(
  parameter int unsigned N    = DefN,
  parameter int unsigned SelW = idx_w(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SelW-1:0] ptr_i,
  output logic [N-1:0]    win_o,
  output logic [SelW-1:0] win_idx_o,
  output logic            any_o
);

  logic [N-1:0]    rot;
  logic [SelW-1:0] src_idx;
  int unsigned     off;

  // rot[k] is the request k+1 positions past the pointer.
  always_comb begin
    rot     = '0;
    src_idx = '0;
    for (int k = 0; k < N; k++) begin
      src_idx = SelW'((int'(ptr_i) + 1 + k) % N);
      rot[k]  = req_i[src_idx];
    end
  end

  always_comb begin
    any_o = 1'b0;
    off   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_o = 1'b1;
        off   = k;
      end
    end
    win_idx_o = SelW'((int'(ptr_i) + 1 + off) % N);
    win_o     = '0;
    if (any_o) win_o[win_idx_o] = 1'b1;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared N:1 data mux onto one valid/ready port,
// with at most MAX_HOLD accepted beats per grant before re-arbitration.
module rr_mux_arbiter import rr_mux_arbiter_pkg::*; #(
  parameter int unsigned N        = DefN,
  parameter int unsigned W        = DefW,
  parameter int unsigned MAX_HOLD = DefMaxHold
) (
  input logic             clk,
  input logic             rst_n,
  rr_mux_arbiter_if.slave bus
);

  localparam int unsigned SelW  = idx_w(N);
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;

  logic            busy, valid, beat, withdraw, last_beat, any;
  logic [N-1:0]    pick_req, win;
  logic [SelW-1:0] win_idx;

  assign busy      = (state_q == StBusy);
  assign valid     = busy & bus.req[sel_q];
  assign beat      = valid & bus.out_ready;
  assign withdraw  = busy & ~bus.req[sel_q];
  assign last_beat = beat && (hold_q == HoldW'(MAX_HOLD - 1));
  // Only a withdrawing holder is excluded; a holder that ran out of beats may win again.
  assign pick_req  = withdraw ? (bus.req & ~grant_q) : bus.req;

  rr_mux_arbiter_pick #(
    .N    (N),
    .SelW (SelW)
  ) u_pick (
    .req_i     (pick_req),
    .ptr_i     (ptr_q),
    .win_o     (win),
    .win_idx_o (win_idx),
    .any_o     (any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (!busy || withdraw || last_beat) begin
      if (any) begin
        state_d = StBusy;
        grant_d = win;
        sel_d   = win_idx;
        ptr_d   = win_idx;
        hold_d  = '0;
      end else begin
        state_d = StIdle;
        grant_d = '0;
        hold_d  = '0;
      end
    end else if (beat) begin
      hold_d = hold_q + HoldW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= SelW'(N - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_q == SelW'(i)) bus.out_data = bus.data_in[i*W +: W];
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = valid;
  assign bus.ack       = beat ? grant_q : '0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N=4, W=8, MAX_HOLD=4) with immediate assertions.
// Inputs change just after the falling edge; outputs are checked 1 unit after it.
module tb_rr_mux_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  rr_mux_arbiter_if #(.N(4), .W(8)) bus ();

  rr_mux_arbiter #(
    .N        (4),
    .W        (8),
    .MAX_HOLD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [3:0] a,
                           input logic v, input logic [1:0] s, input logic [7:0] d);
    check({tag, ".grant"}, 32'(bus.grant), 32'(g));
    check({tag, ".ack"}, 32'(bus.ack), 32'(a));
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".sel"}, 32'(bus.sel), 32'(s));
    check({tag, ".data"}, 32'(bus.out_data), 32'(d));
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] eg;
    logic [1:0] es;
    logic [7:0] ed [4];
    ed[0] = 8'h11; ed[1] = 8'h22; ed[2] = 8'h33; ed[3] = 8'h44;

    // 1: reset with all requesting
    rst_n         = 1'b0;
    bus.req       = 4'b1111;
    bus.data_in   = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.out_ready = 1'b1;
    tick();
    check_all("reset", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h11);
    rst_n = 1'b1;

    // 2: all requesting, 4 beats each, no gaps
    for (int c = 0; c < 17; c++) begin
      tick();
      es = 2'((c / 4) % 4);
      eg = 4'b0001 << es;
      check_all($sformatf("rr%0d", c), eg, eg, 1'b1, es, ed[es]);
    end

    // 3: single requester keeps the bus across hold boundaries
    bus.req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_all($sformatf("solo%0d", c), 4'b0100, 4'b0100, 1'b1, 2'd2, 8'h33);
    end

    // 4: stall holds grant and data stable
    bus.req       = 4'b0010;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_all($sformatf("stall%0d", c), 4'b0010, 4'b0000, 1'b1, 2'd1, 8'h22);
    end
    bus.out_ready = 1'b1;
    #1;
    check("stall_release.ack", 32'(bus.ack), 32'(4'b0010));
    tick();
    check_all("after_stall", 4'b0010, 4'b0010, 1'b1, 2'd1, 8'h22);

    // 5: withdrawal hands over next cycle without a beat
    bus.req = 4'b0001;
    tick();
    check_all("grant0", 4'b0001, 4'b0001, 1'b1, 2'd0, 8'h11);
    bus.req = 4'b1000;
    #1;
    check("withdraw.ack", 32'(bus.ack), 32'(4'b0000));
    check("withdraw.valid", 32'(bus.out_valid), 32'(1'b0));
    tick();
    check_all("handover", 4'b1000, 4'b1000, 1'b1, 2'd3, 8'h44);

    // Idle keeps priority: last grant was 3, then 0 below, so 1 wins after idle
    bus.req = 4'b0001;
    tick();
    check_all("to0", 4'b0001, 4'b0001, 1'b1, 2'd0, 8'h11);
    bus.req = 4'b0000;
    tick();
    check_all("idle", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h11);
    bus.req = 4'b1111;
    tick();
    check_all("after_idle", 4'b0010, 4'b0010, 1'b1, 2'd1, 8'h22);

    // 6: reset mid-burst on requester 2 with two beats taken
    bus.req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_all($sformatf("burst%0d", c), 4'b0100, 4'b0100, 1'b1, 2'd2, 8'h33);
    end
    rst_n = 1'b0;
    #1;
    check_all("mid_reset", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h11);
    bus.req = 4'b1111;
    tick();
    check_all("held_reset", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h11);
    rst_n = 1'b1;
    tick();
    check_all("post_reset", 4'b0001, 4'b0001, 1'b1, 2'd0, 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
